dmem_bus_bridge: RTL and testbench

Bridge between the pipelined core's single-cycle data-memory port and a valid/ready external data bus with variable latency. It registers each core load/store, runs the bus handshake, and holds the MEM stage with a stall until the transfer completes. It also detects bus errors and timeouts. It sits directly downstream of the core's `o_mem_*` / `i_mem_read_data` port.

---
 rtl/dmem_bridge_pkg.sv | 16 +
 rtl/dmem_timeout_counter.sv | 38 +++
 rtl/dmem_bus_bridge.sv | 135 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg
// Shared types and constants for the data-memory bus bridge.
//   dmem_bridge_state_t : bridge FSM state encoding
//   DMEM_ERR_RDATA      : data returned to the core on an erroring or timed-out load
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } dmem_bridge_state_t;

  localparam int unsigned DMEM_ERR_RDATA = 0;

endpackage

// File: rtl/dmem_timeout_counter.sv
// dmem_timeout_counter
// Counts cycles spent waiting on the bus and flags when the wait budget is used up.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_clear        : restart the count at zero (wins over i_enable)
//   i_enable       : count this cycle
//   o_expired      : count has reached TIMEOUT_CYCLES-1
module dmem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so the flag stays up if the owner lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_enable && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == LAST);

endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
// Turns the core's single-cycle load/store port into a valid/ready bus transfer,
// stalling the MEM stage until the transfer completes; records bus errors/timeouts.
//   core side : i_core_addr/wdata/byteen/we/re in, o_core_rdata/o_core_stall out
//   bus side  : o_bus_valid/addr/wdata/byteen/we out, i_bus_ready, i_bus_rvalid,
//               i_bus_rdata, i_bus_err in
//   error     : i_err_clr in, o_err (sticky) and o_err_addr (first failing address) out
module dmem_bus_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_core_addr,
  input  logic [WIDTH-1:0] i_core_wdata,
  input  logic [3:0]       i_core_byteen,
  input  logic             i_core_we,
  input  logic             i_core_re,
  output logic [WIDTH-1:0] o_core_rdata,
  output logic             o_core_stall,
  output logic             o_bus_valid,
  input  logic             i_bus_ready,
  output logic [WIDTH-1:0] o_bus_addr,
  output logic [WIDTH-1:0] o_bus_wdata,
  output logic [3:0]       o_bus_byteen,
  output logic             o_bus_we,
  input  logic             i_bus_rvalid,
  input  logic [WIDTH-1:0] i_bus_rdata,
  input  logic             i_bus_err,
  input  logic             i_err_clr,
  output logic             o_err,
  output logic [WIDTH-1:0] o_err_addr
);

  dmem_bridge_state_t state_q, state_d;

  logic             valid_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q, err_addr_q;
  logic [3:0]       byteen_q;
  logic             we_q, err_q;

  logic core_req, timed_out, abort, err_event, cnt_clear, cnt_enable;

  assign core_req = i_core_we | i_core_re;

  // Clearing on any state change restarts the budget on entry to REQ and WAIT_R.
  assign cnt_clear  = (state_d != state_q);
  assign cnt_enable = (state_q == REQ) || (state_q == WAIT_R);

  dmem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (cnt_clear),
    .i_enable  (cnt_enable),
    .o_expired (timed_out)
  );

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE:   if (core_req) state_d = REQ;
      REQ: begin
        if (i_bus_ready)    state_d = we_q ? DONE : WAIT_R;  // writes are posted
        else if (timed_out) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      WAIT_R: begin
        // A response arriving on the expiry cycle still counts as progress.
        if (i_bus_rvalid)   state_d = DONE;
        else if (timed_out) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_event = ((state_q == WAIT_R) && i_bus_rvalid && i_bus_err) || abort;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      byteen_q   <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == REQ);

      if ((state_q == IDLE) && core_req) begin
        addr_q   <= i_core_addr;
        wdata_q  <= i_core_wdata;
        byteen_q <= i_core_byteen;
        we_q     <= i_core_we;  // we wins when both are set
      end

      if ((state_q == WAIT_R) && i_bus_rvalid)
        rdata_q <= i_bus_err ? WIDTH'(DMEM_ERR_RDATA) : i_bus_rdata;
      else if (abort)
        rdata_q <= WIDTH'(DMEM_ERR_RDATA);

      // Only the first error since the last clear latches its address;
      // a new error on the clear cycle takes over.
      if (err_event && (!err_q || i_err_clr)) begin
        err_q      <= 1'b1;
        err_addr_q <= addr_q;
      end else if (i_err_clr) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end
    end
  end

  assign o_core_stall = ((state_q == IDLE) && core_req) || (state_q == REQ) || (state_q == WAIT_R);
  assign o_core_rdata = rdata_q;
  assign o_bus_valid  = valid_q;
  assign o_bus_addr   = addr_q;
  assign o_bus_wdata  = wdata_q;
  assign o_bus_byteen = byteen_q;
  assign o_bus_we     = we_q;
  assign o_err        = err_q;
  assign o_err_addr   = err_addr_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge
// Directed checks of the data-memory bus bridge: loads, stores with backpressure,
// bus errors, timeout, simultaneous we+re and reset during a transfer.
module tb_dmem_bus_bridge;

  localparam int W = 32;

  logic         clk, rst;
  logic [W-1:0] core_addr, core_wdata, core_rdata;
  logic [3:0]   core_byteen, bus_byteen;
  logic         core_we, core_re, core_stall;
  logic         bus_valid, bus_ready, bus_we, bus_rvalid, bus_err;
  logic [W-1:0] bus_addr, bus_wdata, bus_rdata;
  logic         err_clr, err;
  logic [W-1:0] err_addr;

  int n_chk = 0;
  int n_err = 0;
  int stall_cnt;

  dmem_bus_bridge #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_core_addr   (core_addr),
    .i_core_wdata  (core_wdata),
    .i_core_byteen (core_byteen),
    .i_core_we     (core_we),
    .i_core_re     (core_re),
    .o_core_rdata  (core_rdata),
    .o_core_stall  (core_stall),
    .o_bus_valid   (bus_valid),
    .i_bus_ready   (bus_ready),
    .o_bus_addr    (bus_addr),
    .o_bus_wdata   (bus_wdata),
    .o_bus_byteen  (bus_byteen),
    .o_bus_we      (bus_we),
    .i_bus_rvalid  (bus_rvalid),
    .i_bus_rdata   (bus_rdata),
    .i_bus_err     (bus_err),
    .i_err_clr     (err_clr),
    .o_err         (err),
    .o_err_addr    (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Zero-wait load; returns in the DONE cycle with the request already dropped.
  task automatic run_read(input logic [W-1:0] a, input logic [W-1:0] d, input logic be);
    @(negedge clk); core_re = 1'b1; core_addr = a;
    #1 check("rd_idle_stall", W'(core_stall), 1);
    check("rd_idle_valid", W'(bus_valid), 0);
    @(negedge clk); bus_ready = 1'b1;
    #1 check("rd_req_valid", W'(bus_valid), 1);
    check("rd_req_addr", bus_addr, a);
    check("rd_req_we", W'(bus_we), 0);
    check("rd_req_stall", W'(core_stall), 1);
    @(negedge clk); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF ^ 32'h0 | d; bus_err = be;
    if (!be) bus_rdata = d;
    #1 check("rd_wait_valid", W'(bus_valid), 0);
    check("rd_wait_stall", W'(core_stall), 1);
    @(negedge clk); bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    #1 check("rd_done_stall", W'(core_stall), 0);
    core_re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; core_addr = '0; core_wdata = '0; core_byteen = '0;
    core_we = 1'b0; core_re = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    bus_rdata = '0; bus_err = 1'b0; err_clr = 1'b0;

    // Reset state; stall follows the core request even while in reset.
    @(negedge clk); core_re = 1'b1;
    #1 check("rst_stall_req", W'(core_stall), 1);
    check("rst_valid", W'(bus_valid), 0);
    check("rst_we", W'(bus_we), 0);
    check("rst_addr", bus_addr, 0);
    check("rst_byteen", W'(bus_byteen), 0);
    check("rst_rdata", core_rdata, 0);
    check("rst_err", W'(err), 0);
    check("rst_err_addr", err_addr, 0);
    core_re = 1'b0;
    #1 check("rst_stall_noreq", W'(core_stall), 0);
    @(negedge clk); rst = 1'b0;

    // Load, zero wait.
    run_read(32'h100, 32'hCAFE_F00D, 1'b0);
    check("load_rdata", core_rdata, 32'hCAFE_F00D);
    check("load_err", W'(err), 0);
    @(negedge clk);
    #1 check("load_rdata_hold", core_rdata, 32'hCAFE_F00D);
    check("load_idle_stall", W'(core_stall), 0);

    // Store with 5 cycles of backpressure: 6 REQ cycles, 7 stall cycles total.
    stall_cnt = 0;
    @(negedge clk); core_we = 1'b1; core_addr = 32'h200; core_wdata = 32'h1234_5678; core_byteen = 4'b0011;
    #1 if (core_stall) stall_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); bus_ready = (i == 5);
      #1 check($sformatf("st_valid_%0d", i), W'(bus_valid), 1);
      check($sformatf("st_addr_%0d", i), bus_addr, 32'h200);
      check($sformatf("st_wdata_%0d", i), bus_wdata, 32'h1234_5678);
      check($sformatf("st_byteen_%0d", i), W'(bus_byteen), 4'b0011);
      check($sformatf("st_we_%0d", i), W'(bus_we), 1);
      if (core_stall) stall_cnt++;
    end
    @(negedge clk); bus_ready = 1'b0;
    #1 check("st_done_stall", W'(core_stall), 0);
    check("st_done_valid", W'(bus_valid), 0);
    check("st_stall_cycles", W'(stall_cnt), 7);
    core_we = 1'b0;

    // Bus error on load; second error keeps the first address; clear.
    run_read(32'h300, 32'h5555_AAAA, 1'b1);
    check("err1_rdata", core_rdata, 0);
    check("err1_flag", W'(err), 1);
    check("err1_addr", err_addr, 32'h300);
    run_read(32'h304, 32'h1111_2222, 1'b1);
    check("err2_flag", W'(err), 1);
    check("err2_addr", err_addr, 32'h300);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1 check("clr_flag", W'(err), 0);
    check("clr_addr", err_addr, 0);

    // Timeout: ready never comes, abort after 8 REQ cycles.
    @(negedge clk); core_we = 1'b1; core_addr = 32'h400; core_wdata = 32'hA5A5_A5A5; core_byteen = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 check($sformatf("to_valid_%0d", i), W'(bus_valid), 1);
      check($sformatf("to_stall_%0d", i), W'(core_stall), 1);
    end
    @(negedge clk);
    #1 check("to_done_stall", W'(core_stall), 0);
    check("to_valid_drop", W'(bus_valid), 0);
    check("to_err", W'(err), 1);
    check("to_err_addr", err_addr, 32'h400);
    core_we = 1'b0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Simultaneous we+re is a write: accept goes straight to DONE.
    @(negedge clk); core_we = 1'b1; core_re = 1'b1; core_addr = 32'h500; core_wdata = 32'h0BAD_F00D;
    @(negedge clk); bus_ready = 1'b1;
    #1 check("wr_rd_we", W'(bus_we), 1);
    check("wr_rd_valid", W'(bus_valid), 1);
    @(negedge clk); bus_ready = 1'b0;
    #1 check("wr_rd_done_stall", W'(core_stall), 0);
    core_we = 1'b0; core_re = 1'b0;

    // Reset while in WAIT_R; a late response afterwards is ignored.
    @(negedge clk); core_re = 1'b1; core_addr = 32'h600;
    @(negedge clk); bus_ready = 1'b1;
    @(negedge clk); bus_ready = 1'b0;
    #1 check("mrst_wait_stall", W'(core_stall), 1);
    rst = 1'b1;
    #1 check("mrst_valid", W'(bus_valid), 0);
    check("mrst_stall_req", W'(core_stall), 1);
    @(negedge clk); core_re = 1'b0; rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    #1 check("mrst_idle_stall", W'(core_stall), 0);
    @(negedge clk); bus_rvalid = 1'b0;
    #1 check("mrst_rdata", core_rdata, 0);
    check("mrst_valid2", W'(bus_valid), 0);
    check("mrst_stall2", W'(core_stall), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
